digota_sar_ctrl: RTL and testbench

Successive-approximation controller that sequences the digital OTA comparator as the decision element of a SAR ADC. It drives the track/hold `sample` strobe and the trial DAC code, synchronizes the asynchronous comparator output, and performs a MSB-first binary search. It presents the converted code on a valid/ready output. It sits between the chip's digital control (start/result) and the analog front end (DAC + digital OTA).

---
 rtl/digota_pkg.sv | 17 +
 rtl/digota_sync2.sv | 22 ++
 rtl/digota_sar_ctrl.sv | 143 ++++++++++++++
 tb/tb_digota_sar_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/digota_pkg.sv
// Shared types and default parameters for the SAR controller that drives the
// digital OTA comparator.
package digota_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SAMPLE = 3'd1,
    ST_SETTLE = 3'd2,
    ST_DECIDE = 3'd3,
    ST_DONE   = 3'd4
  } sar_state_t;

  localparam int SAR_WIDTH         = 8;
  localparam int SAR_SAMPLE_CYCLES = 2;
  localparam int SAR_SETTLE        = 3;

endpackage

// File: rtl/digota_sync2.sv
// Two-flop synchronizer for a single asynchronous bit; cleared by the
// synchronous reset.
module digota_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/digota_sar_ctrl.sv
// SAR controller: track/hold strobe, MSB-first binary search on the DAC code
// using the synchronized comparator decision, result on a valid/ready port.
module digota_sar_ctrl
  import digota_pkg::*;
#(
  parameter int WIDTH         = SAR_WIDTH,
  parameter int SAMPLE_CYCLES = SAR_SAMPLE_CYCLES,
  parameter int SETTLE        = SAR_SETTLE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cmp_in,
  output logic             sample,
  output logic [WIDTH-1:0] dac_code,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  input  logic             result_ready
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int SW = $clog2(SETTLE + 1);
  localparam int CW = $clog2(SAMPLE_CYCLES + 1);

  localparam logic [IW-1:0]    IDX_MSB     = IW'(WIDTH - 1);
  localparam logic [IW-1:0]    IDX_ONE     = IW'(1);
  localparam logic [SW-1:0]    SETTLE_LOAD = SW'(SETTLE - 1);
  localparam logic [SW-1:0]    SETTLE_ONE  = SW'(1);
  localparam logic [CW-1:0]    SAMP_LOAD   = CW'(SAMPLE_CYCLES - 1);
  localparam logic [CW-1:0]    SAMP_ONE    = CW'(1);
  localparam logic [WIDTH-1:0] MSB_CODE    = {1'b1, {(WIDTH-1){1'b0}}};

  sar_state_t       state_q, state_d;
  logic [CW-1:0]    samp_cnt_q;
  logic [SW-1:0]    settle_cnt_q;
  logic [IW-1:0]    bit_idx_q;
  logic [WIDTH-1:0] code_q, result_q;
  logic [WIDTH-1:0] decided, next_trial;
  logic             cmp_sync;

  // The only path from the asynchronous comparator into the controller.
  digota_sync2 u_cmp_sync (
    .clk (clk),
    .rst (rst),
    .d   (cmp_in),
    .q   (cmp_sync)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Result handshake: result_valid is high for the whole DONE state and
  // result is frozen there; a transfer happens on any clock edge where
  // result_valid && result_ready, after which the controller is idle.
  always_comb begin
    state_d      = state_q;
    sample       = 1'b0;
    busy         = 1'b0;
    result_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        sample = 1'b1;
        busy   = 1'b1;
        if (samp_cnt_q == '0) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        busy = 1'b1;
        if (settle_cnt_q == '0) state_d = ST_DECIDE;
      end
      ST_DECIDE: begin
        busy    = 1'b1;
        state_d = (bit_idx_q == '0) ? ST_DONE : ST_SETTLE;
      end
      ST_DONE: begin
        result_valid = 1'b1;
        if (result_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Current trial bit is already set, so writing the decision into it keeps
  // or clears it; the next lower bit becomes the following trial.
  always_comb begin
    decided            = code_q;
    decided[bit_idx_q] = cmp_sync;
    next_trial         = decided;
    if (bit_idx_q != '0) next_trial[bit_idx_q - IDX_ONE] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      samp_cnt_q   <= '0;
      settle_cnt_q <= '0;
      bit_idx_q    <= '0;
      code_q       <= '0;
      result_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          samp_cnt_q <= SAMP_LOAD;
          code_q     <= '0;
        end
        ST_SAMPLE: begin
          if (samp_cnt_q == '0) begin
            bit_idx_q    <= IDX_MSB;
            code_q       <= MSB_CODE;
            settle_cnt_q <= SETTLE_LOAD;
          end else begin
            samp_cnt_q <= samp_cnt_q - SAMP_ONE;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt_q != '0) settle_cnt_q <= settle_cnt_q - SETTLE_ONE;
        end
        ST_DECIDE: begin
          if (bit_idx_q != '0) begin
            code_q       <= next_trial;
            bit_idx_q    <= bit_idx_q - IDX_ONE;
            settle_cnt_q <= SETTLE_LOAD;
          end else begin
            code_q   <= decided;
            result_q <= decided;
          end
        end
        ST_DONE: begin
          if (result_ready) code_q <= '0;
        end
        default: code_q <= '0;
      endcase
    end
  end

  assign dac_code = code_q;
  assign result   = result_q;

endmodule

// File: tb/tb_digota_sar_ctrl.sv
// Directed/randomized bench for digota_sar_ctrl against an ideal-comparator
// SAR reference model.
module tb_digota_sar_ctrl;
  import digota_pkg::*;

  localparam int W    = SAR_WIDTH;
  localparam int S    = SAR_SAMPLE_CYCLES;
  localparam int ST   = SAR_SETTLE;
  localparam int LAT  = S + W * (ST + 1);
  localparam int ST2  = 2;
  localparam int LAT2 = S + W * (ST2 + 1);

  logic         clk, rst;
  logic         start, cmp_in, sample, busy, result_valid, result_ready;
  logic [W-1:0] dac_code, result;
  logic         start2, cmp_in2, sample2, busy2, result_valid2, result_ready2;
  logic [W-1:0] dac_code2, result2;

  logic [W-1:0] vin_code, vin2;
  logic         glitch_en, glitch_val, protect;

  int           tests_run;
  int           n_fail;
  logic [W-1:0] exp_q[$];

  // Ideal comparator, optionally replaced by a glitching source.
  assign cmp_in  = glitch_en ? glitch_val : (vin_code >= dac_code);
  assign cmp_in2 = (vin2 >= dac_code2);

  digota_sar_ctrl u_dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .cmp_in       (cmp_in),
    .sample       (sample),
    .dac_code     (dac_code),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready)
  );

  digota_sar_ctrl #(.SETTLE(ST2)) u_dut2 (
    .clk          (clk),
    .rst          (rst),
    .start        (start2),
    .cmp_in       (cmp_in2),
    .sample       (sample2),
    .dac_code     (dac_code2),
    .busy         (busy2),
    .result       (result2),
    .result_valid (result_valid2),
    .result_ready (result_ready2)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Asynchronous comparator glitching outside the protected window.
  always begin
    #3;
    if (glitch_en && !protect) glitch_val = 1'($urandom_range(0, 1));
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: trial for bit b is vin's bits above b with bit b set.
  function automatic logic [W-1:0] trial_code(input logic [W-1:0] vin, input int b);
    logic [W-1:0] hi;
    hi = vin >> (b + 1);
    hi = hi << (b + 1);
    return hi | (W'(1) << b);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every accepted result is matched against the expected queue.
  always @(negedge clk) begin
    if (!rst && result_valid && result_ready) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        n_fail++;
        $error("FAIL sb_unexpected: observed %0h expected none", result);
      end else begin
        check("sb_result", 32'(result), 32'(exp_q.pop_front()));
      end
    end
  end

  // Driver: one conversion with optional backpressure and comparator glitching.
  task automatic run_conv(input logic [W-1:0] vin, input int stall, input bit glitch);
    int lat;
    bit bad, bad2;
    vin_code     = vin;
    glitch_en    = glitch;
    protect      = 1'b0;
    glitch_val   = 1'b0;
    result_ready = (stall == 0);
    start        = 1'b1;
    exp_q.push_back(vin);
    step();
    check("start_busy", 32'({sample, busy}), 32'(2'b11));
    start = 1'b0;
    lat   = -1;
    bad   = 1'b0;
    bad2  = 1'b0;
    for (int k = 1; k <= LAT + 40 && lat < 0; k++) begin
      step();
      if (result_valid) begin
        lat = k;
      end else begin
        if (sample != (k < S) || !busy) bad = 1'b1;
        if (k >= S) begin
          int r, i;
          r = (k - S) % (ST + 1);
          i = (k - S) / (ST + 1);
          if (r == 0 && i < W) begin
            check($sformatf("trial%0d", i), 32'(dac_code), 32'(trial_code(vin, W - 1 - i)));
            if (glitch) begin
              glitch_val = (vin >= dac_code);
              protect    = 1'b1;
            end
          end
          if (r == ST) protect = 1'b0;
        end
      end
    end
    glitch_en = 1'b0;
    protect   = 1'b0;
    check("latency", 32'(lat), 32'(LAT));
    check("conv_phase", 32'(bad), 32'(0));
    if (lat < 0) begin
      exp_q.delete();
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
    end else begin
      for (int s = 0; s < stall - 1; s++) begin
        start = 1'($urandom_range(0, 1));
        step();
        if (!result_valid || result !== vin || busy) bad2 = 1'b1;
      end
      if (stall > 0) check("stall_hold", 32'(bad2), 32'(0));
      result_ready = 1'b1;
      start        = (stall > 0);
      step();
      check("idle_after", 32'({result_valid, busy, sample, dac_code}), 32'(0));
      start = 1'b0;
      step();
      check("no_restart", 32'({sample, busy}), 32'(0));
    end
  endtask

  initial begin
    int t[$];
    int lat2;
    bit bad, prev_s;
    tests_run     = 0;
    n_fail        = 0;
    rst           = 1'b1;
    start         = 1'b0;
    result_ready  = 1'b0;
    vin_code      = '0;
    glitch_en     = 1'b0;
    glitch_val    = 1'b0;
    protect       = 1'b0;
    start2        = 1'b0;
    result_ready2 = 1'b1;
    vin2          = 8'hA5;
    repeat (3) step();
    check("reset_out", 32'({sample, busy, result_valid, dac_code, result}), 32'(0));
    check("reset_out2", 32'({sample2, busy2, result_valid2, dac_code2, result2}), 32'(0));
    rst = 1'b0;
    step();

    // Directed codes and boundaries
    run_conv(8'hA5, 0, 1'b0);
    run_conv(8'h00, 0, 1'b0);
    run_conv(8'hFF, 0, 1'b0);

    // Backpressure with ignored start pulses
    run_conv(W'($urandom), 10, 1'b0);
    repeat (4) run_conv(W'($urandom), $urandom_range(0, 3), 1'b0);

    // Continuous start: SAMPLE entries spaced LAT+2
    result_ready = 1'b1;
    vin_code     = W'($urandom);
    start        = 1'b1;
    prev_s       = 1'b0;
    for (int c = 0; c < 4 * (LAT + 2) + 5 && t.size() < 4; c++) begin
      step();
      if (sample && !prev_s) begin
        t.push_back(c);
        vin_code = W'($urandom);
        exp_q.push_back(vin_code);
      end
      prev_s = sample;
    end
    start = 1'b0;
    check("cont_count", 32'(t.size()), 32'(4));
    if (t.size() == 4) begin
      for (int i = 1; i < 4; i++) check($sformatf("cont_space%0d", i), 32'(t[i] - t[i-1]), 32'(LAT + 2));
    end
    for (int c = 0; c < LAT + 10 && (busy || result_valid); c++) step();
    step();
    check("cont_drain", 32'(exp_q.size()), 32'(0));
    exp_q.delete();

    // Reset in SETTLE of bit 4
    vin_code = W'($urandom_range(1, 255));
    start    = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= S + 3 * (ST + 1) + 1; k++) step();
    check("abort_pre", 32'(dac_code), 32'(trial_code(vin_code, 4)));
    rst = 1'b1;
    step();
    check("abort_out", 32'({sample, busy, result_valid, dac_code, result}), 32'(0));
    rst = 1'b0;
    bad = 1'b0;
    repeat (LAT + 10) begin
      step();
      if (result_valid || busy) bad = 1'b1;
    end
    check("abort_no_valid", 32'(bad), 32'(0));
    run_conv(8'h3C, 0, 1'b0);

    // Glitching comparator, stable only before each decision
    run_conv(8'hA5, 0, 1'b1);
    repeat (2) run_conv(W'($urandom), 0, 1'b1);

    // SETTLE=2 build on the 0xA5 case
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    lat2   = -1;
    for (int k = 1; k <= LAT2 + 40 && lat2 < 0; k++) begin
      step();
      if (result_valid2) begin
        lat2 = k;
        check("s2_result", 32'(result2), 32'(vin2));
      end
    end
    check("s2_latency", 32'(lat2), 32'(LAT2));

    repeat (3) step();
    check("sb_final_empty", 32'(exp_q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", tests_run, n_fail);
    $finish;
  end

endmodule
